// File: rtl/matmul_pkg.sv
// matmul_pkg -- shared definitions for the blocked matrix-multiply tile scheduler.
//   state_t     : scheduler FSM states (IDLE, ISSUE, WAIT, NEXT, DONE)
//   cdiv        : ceiling divide, used for tile counts
//   min_ext     : extent of a tile that may be clipped by the matrix edge
//   width_of    : index width for a range of n values (never below 1 bit)
package matmul_pkg;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_NEXT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = S_IDLE,
      ISSUE = S_ISSUE,
      WAIT  = S_WAIT,
      NEXT  = S_NEXT,
      DONE  = S_DONE
   } state_t;

   function automatic int cdiv(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   function automatic int min_ext(input int block, input int size, input int base);
      return ((size - base) < block) ? (size - base) : block;
   endfunction

   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matmul_tile_cnt.sv
// matmul_tile_cnt -- one loop level of the tile walk (row, col or k).
// Ports:
//   clock, reset (sync, active-low)
//   clear   : return base to 0
//   step    : advance to the next tile; wraps to 0 after the last one
//   base    : first index of the current tile
//   extent  : tile size, clipped at the matrix edge
//   is_last : current tile is the last one of this level
//   wrap    : step taken on the last tile (steps the next outer level)
module matmul_tile_cnt
   import matmul_pkg::*;
#(
   parameter int SIZE  = 10,
   parameter int BLOCK = 5,
   parameter int BW    = width_of(SIZE),
   parameter int EW    = width_of(BLOCK + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          step,
   output logic [BW-1:0] base,
   output logic [EW-1:0] extent,
   output logic          is_last,
   output logic          wrap
);

   localparam int LAST_BASE = (cdiv(SIZE, BLOCK) - 1) * BLOCK;

   logic [BW-1:0] base_reg;

   always_ff @(posedge clock) begin
      if (!reset) begin
         base_reg <= '0;
      end else if (clear) begin
         base_reg <= '0;
      end else if (step) begin
         // base + BLOCK only fits when this is not the last tile, which is
         // exactly when it is taken.
         base_reg <= is_last ? '0 : base_reg + BW'(BLOCK);
      end
   end

   assign base    = base_reg;
   assign is_last = (int'(base_reg) == LAST_BASE);
   assign extent  = EW'(min_ext(BLOCK, SIZE, int'(base_reg)));
   assign wrap    = step & is_last;

endmodule

// File: rtl/matmul_tile_scheduler.sv
// matmul_tile_scheduler -- tile-loop sequencer for the blocked matrix multiply.
// Walks C in FIRST_BLOCK_ROW_SIZE x SECOND_BLOCK_COL_SIZE tiles (row outer,
// col middle) and the shared dimension in BLOCK_SIZE steps (innermost), one
// command outstanding at a time.
// Ports:
//   clock, reset (sync, active-low), start
//   busy, done, k_done                      : status / pulses
//   tile_valid, tile_ready                  : command handshake
//   tile_row_base, tile_col_base, tile_k_base, tile_rows, tile_cols,
//   tile_depth, tile_first_k, tile_last_k   : registered command fields
//   tile_done                               : engine completion
// Optional (macro TILE_SCHED_PERF_EN): cycle_count, stall_count.
module matmul_tile_scheduler
   import matmul_pkg::*;
#(
   parameter int FIRST_MATRIX_ROW_SIZE  = 20,
   parameter int MATRIX_SIZE            = 10,
   parameter int SECOND_MATRIX_COL_SIZE = 30,
   parameter int FIRST_BLOCK_ROW_SIZE   = 5,
   parameter int BLOCK_SIZE             = 5,
   parameter int SECOND_BLOCK_COL_SIZE  = 5,
   localparam int RW  = width_of(FIRST_MATRIX_ROW_SIZE),
   localparam int CW  = width_of(SECOND_MATRIX_COL_SIZE),
   localparam int KW  = width_of(MATRIX_SIZE),
   localparam int REW = width_of(FIRST_BLOCK_ROW_SIZE + 1),
   localparam int CEW = width_of(SECOND_BLOCK_COL_SIZE + 1),
   localparam int KEW = width_of(BLOCK_SIZE + 1)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic           k_done,
   output logic           tile_valid,
   input  logic           tile_ready,
   output logic [RW-1:0]  tile_row_base,
   output logic [CW-1:0]  tile_col_base,
   output logic [KW-1:0]  tile_k_base,
   output logic [REW-1:0] tile_rows,
   output logic [CEW-1:0] tile_cols,
   output logic [KEW-1:0] tile_depth,
   output logic           tile_first_k,
   output logic           tile_last_k,
   input  logic           tile_done
`ifdef TILE_SCHED_PERF_EN
   ,
   output logic [31:0]    cycle_count,
   output logic [31:0]    stall_count
`endif
);

   state_t state_reg, state_next;

   logic [RW-1:0]  row_base;
   logic [CW-1:0]  col_base;
   logic [KW-1:0]  k_base;
   logic [REW-1:0] row_ext;
   logic [CEW-1:0] col_ext;
   logic [KEW-1:0] k_ext;
   logic           row_last, col_last, k_last;
   logic           row_wrap, col_wrap, k_wrap;
   logic           all_last;

   logic           cnt_clear, cnt_adv, load_cmd;

   logic [RW-1:0]  row_base_reg;
   logic [CW-1:0]  col_base_reg;
   logic [KW-1:0]  k_base_reg;
   logic [REW-1:0] rows_reg;
   logic [CEW-1:0] cols_reg;
   logic [KEW-1:0] depth_reg;
   logic           first_k_reg, last_k_reg;
   logic           done_reg, k_done_reg;

   // Counters advance at the end of WAIT, so in NEXT they already point at
   // the following tile and the command registers load from them directly.
   // They also wrap back to 0 after the final tile, so IDLE always sees zero.
   assign cnt_clear = (state_reg == IDLE) && start;
   assign cnt_adv   = (state_reg == WAIT) && tile_done;
   assign load_cmd  = cnt_clear || (state_reg == NEXT);
   assign all_last  = row_last & col_last & k_last;

   matmul_tile_cnt #(.SIZE(MATRIX_SIZE), .BLOCK(BLOCK_SIZE), .BW(KW), .EW(KEW)) u_k_cnt (
      .clock(clock), .reset(reset), .clear(cnt_clear), .step(cnt_adv),
      .base(k_base), .extent(k_ext), .is_last(k_last), .wrap(k_wrap)
   );

   matmul_tile_cnt #(.SIZE(SECOND_MATRIX_COL_SIZE), .BLOCK(SECOND_BLOCK_COL_SIZE), .BW(CW), .EW(CEW)) u_col_cnt (
      .clock(clock), .reset(reset), .clear(cnt_clear), .step(k_wrap),
      .base(col_base), .extent(col_ext), .is_last(col_last), .wrap(col_wrap)
   );

   matmul_tile_cnt #(.SIZE(FIRST_MATRIX_ROW_SIZE), .BLOCK(FIRST_BLOCK_ROW_SIZE), .BW(RW), .EW(REW)) u_row_cnt (
      .clock(clock), .reset(reset), .clear(cnt_clear), .step(col_wrap),
      .base(row_base), .extent(row_ext), .is_last(row_last), .wrap(row_wrap)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start)      state_next = ISSUE;
         ISSUE:   if (tile_ready) state_next = WAIT;
         WAIT:    if (tile_done)  state_next = all_last ? DONE : NEXT;
         NEXT:                    state_next = ISSUE;
         DONE:                    state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg    <= IDLE;
         row_base_reg <= '0;
         col_base_reg <= '0;
         k_base_reg   <= '0;
         rows_reg     <= '0;
         cols_reg     <= '0;
         depth_reg    <= '0;
         first_k_reg  <= 1'b0;
         last_k_reg   <= 1'b0;
         done_reg     <= 1'b0;
         k_done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         // The row counter wraps only when the final tile completes.
         done_reg   <= row_wrap;
         k_done_reg <= cnt_adv & k_last;
         if (load_cmd) begin
            row_base_reg <= row_base;
            col_base_reg <= col_base;
            k_base_reg   <= k_base;
            rows_reg     <= row_ext;
            cols_reg     <= col_ext;
            depth_reg    <= k_ext;
            first_k_reg  <= (k_base == '0);
            last_k_reg   <= k_last;
         end
      end
   end

   assign busy          = (state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == NEXT);
   assign tile_valid    = (state_reg == ISSUE);
   assign done          = done_reg;
   assign k_done        = k_done_reg;
   assign tile_row_base = row_base_reg;
   assign tile_col_base = col_base_reg;
   assign tile_k_base   = k_base_reg;
   assign tile_rows     = rows_reg;
   assign tile_cols     = cols_reg;
   assign tile_depth    = depth_reg;
   assign tile_first_k  = first_k_reg;
   assign tile_last_k   = last_k_reg;

`ifdef TILE_SCHED_PERF_EN
   logic [31:0] cycle_count_reg, stall_count_reg;

   always_ff @(posedge clock) begin
      if (!reset || cnt_clear) begin
         cycle_count_reg <= '0;
         stall_count_reg <= '0;
      end else begin
         if (busy)                      cycle_count_reg <= cycle_count_reg + 32'd1;
         if (tile_valid && !tile_ready) stall_count_reg <= stall_count_reg + 32'd1;
      end
   end

   assign cycle_count = cycle_count_reg;
   assign stall_count = stall_count_reg;
`endif

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: three instances (default sizes, edge-tile
// sizes, single-tile sizes) driven one at a time by a bench-side engine model.
// Expected commands come from nested loops over the matrix in block steps.
module tb_matmul_tile_scheduler;

   typedef struct {
      int r, c, k, rows, cols, depth;
      bit fk, lk;
   } cmd_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic tile_ready = 1'b0;
   logic tile_done = 1'b0;
   int   sel = 0;

   always #5 clock = ~clock;

   logic start_a, start_b, start_c;
   assign start_a = start & (sel == 0);
   assign start_b = start & (sel == 1);
   assign start_c = start & (sel == 2);

   logic a_busy, a_done, a_kd, a_valid, a_fk, a_lk;
   logic [4:0] a_rb, a_cb;
   logic [3:0] a_kb;
   logic [2:0] a_rows, a_cols, a_depth;
`ifdef TILE_SCHED_PERF_EN
   logic [31:0] a_cc, a_sc;
`endif

   logic b_busy, b_done, b_kd, b_valid, b_fk, b_lk;
   logic [2:0] b_rb, b_cb, b_kb;
   logic [2:0] b_rows, b_cols, b_depth;

   logic c_busy, c_done, c_kd, c_valid, c_fk, c_lk;
   logic [1:0] c_rb, c_kb;
   logic [0:0] c_cb;
   logic [2:0] c_rows, c_cols, c_depth;

   matmul_tile_scheduler u_dut_a (
      .clock(clock), .reset(reset), .start(start_a), .busy(a_busy), .done(a_done),
      .k_done(a_kd), .tile_valid(a_valid), .tile_ready(tile_ready),
      .tile_row_base(a_rb), .tile_col_base(a_cb), .tile_k_base(a_kb),
      .tile_rows(a_rows), .tile_cols(a_cols), .tile_depth(a_depth),
      .tile_first_k(a_fk), .tile_last_k(a_lk), .tile_done(tile_done)
`ifdef TILE_SCHED_PERF_EN
      , .cycle_count(a_cc), .stall_count(a_sc)
`endif
   );

   matmul_tile_scheduler #(.FIRST_MATRIX_ROW_SIZE(7), .MATRIX_SIZE(6), .SECOND_MATRIX_COL_SIZE(8)) u_dut_b (
      .clock(clock), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
      .k_done(b_kd), .tile_valid(b_valid), .tile_ready(tile_ready),
      .tile_row_base(b_rb), .tile_col_base(b_cb), .tile_k_base(b_kb),
      .tile_rows(b_rows), .tile_cols(b_cols), .tile_depth(b_depth),
      .tile_first_k(b_fk), .tile_last_k(b_lk), .tile_done(tile_done)
   );

   matmul_tile_scheduler #(.FIRST_MATRIX_ROW_SIZE(3), .MATRIX_SIZE(4), .SECOND_MATRIX_COL_SIZE(2)) u_dut_c (
      .clock(clock), .reset(reset), .start(start_c), .busy(c_busy), .done(c_done),
      .k_done(c_kd), .tile_valid(c_valid), .tile_ready(tile_ready),
      .tile_row_base(c_rb), .tile_col_base(c_cb), .tile_k_base(c_kb),
      .tile_rows(c_rows), .tile_cols(c_cols), .tile_depth(c_depth),
      .tile_first_k(c_fk), .tile_last_k(c_lk), .tile_done(tile_done)
   );

   // Outputs of the selected instance, widened to int.
   int o_busy, o_done, o_kd, o_valid, o_rb, o_cb, o_kb, o_rows, o_cols, o_depth, o_fk, o_lk;
   always_comb begin
      o_busy = 0; o_done = 0; o_kd = 0; o_valid = 0; o_rb = 0; o_cb = 0; o_kb = 0;
      o_rows = 0; o_cols = 0; o_depth = 0; o_fk = 0; o_lk = 0;
      case (sel)
         0: begin
            o_busy = int'(a_busy); o_done = int'(a_done); o_kd = int'(a_kd); o_valid = int'(a_valid);
            o_rb = int'(a_rb); o_cb = int'(a_cb); o_kb = int'(a_kb);
            o_rows = int'(a_rows); o_cols = int'(a_cols); o_depth = int'(a_depth);
            o_fk = int'(a_fk); o_lk = int'(a_lk);
         end
         1: begin
            o_busy = int'(b_busy); o_done = int'(b_done); o_kd = int'(b_kd); o_valid = int'(b_valid);
            o_rb = int'(b_rb); o_cb = int'(b_cb); o_kb = int'(b_kb);
            o_rows = int'(b_rows); o_cols = int'(b_cols); o_depth = int'(b_depth);
            o_fk = int'(b_fk); o_lk = int'(b_lk);
         end
         default: begin
            o_busy = int'(c_busy); o_done = int'(c_done); o_kd = int'(c_kd); o_valid = int'(c_valid);
            o_rb = int'(c_rb); o_cb = int'(c_cb); o_kb = int'(c_kb);
            o_rows = int'(c_rows); o_cols = int'(c_cols); o_depth = int'(c_depth);
            o_fk = int'(c_fk); o_lk = int'(c_lk);
         end
      endcase
   end

   cmd_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic check_cmd(input cmd_t e);
      check("row_base", o_rb, e.r);
      check("col_base", o_cb, e.c);
      check("k_base", o_kb, e.k);
      check("tile_rows", o_rows, e.rows);
      check("tile_cols", o_cols, e.cols);
      check("tile_depth", o_depth, e.depth);
      check("first_k", o_fk, int'(e.fk));
      check("last_k", o_lk, int'(e.lk));
   endtask

   task automatic check_zero();
      cmd_t z;
      z = '{0, 0, 0, 0, 0, 0, 1'b0, 1'b0};
      check("zero_busy", o_busy, 0);
      check("zero_done", o_done, 0);
      check("zero_k_done", o_kd, 0);
      check("zero_valid", o_valid, 0);
      check_cmd(z);
   endtask

   // Reference tile walk: row outer, col middle, k inner; all blocks are 5.
   function automatic void build(input int nr, input int nk, input int nc);
      cmd_t t;
      exp_q.delete();
      for (int r = 0; r < nr; r += 5)
         for (int c = 0; c < nc; c += 5)
            for (int k = 0; k < nk; k += 5) begin
               t.r = r; t.c = c; t.k = k;
               t.rows  = (nr - r < 5) ? nr - r : 5;
               t.cols  = (nc - c < 5) ? nc - c : 5;
               t.depth = (nk - k < 5) ? nk - k : 5;
               t.fk = (k == 0);
               t.lk = (k + 5 >= nk);
               exp_q.push_back(t);
            end
   endfunction

   // One full job on instance s. ideal: ready always high, tile_done right
   // after acceptance; otherwise random ready and latency. Tiles stall_a and
   // stall_b see 5 cycles of ready low. inject: start pulsed in WAIT and
   // tile_done pulsed in ISSUE. reset_tile: pull reset in WAIT of that tile.
   task automatic run_job(input int s, input bit ideal, input int stall_a, input int stall_b,
                          input bit inject, input int reset_tile);
      int n = 0, stalls = 0, busy_cyc = 0, kd_seen = 0, kd_exp = 0, lat = 0, stall_left = 5;
      bit in_wait = 0, held = 0, kd_due = 0, done_due = 0, gap_chk = 0, finished = 0;
      int total;
      total = exp_q.size();
      foreach (exp_q[i]) if (exp_q[i].lk) kd_exp++;
      sel = s;
      start = 1'b1; tile_ready = 1'b0; tile_done = 1'b0;
      tick();
      for (int cyc = 1; cyc < 3000 && !finished; cyc++) begin
         check("k_done", o_kd, int'(kd_due));
         check("done", o_done, int'(done_due));
         if (o_kd != 0) kd_seen++;
         if (o_busy != 0) busy_cyc++;
         if (gap_chk) check("valid_after_tile_done", o_valid, 0);
         if (done_due) begin
            check("busy_in_done", o_busy, 0);
            check("cmd_count", n, total);
            if (ideal) check("done_cycle", cyc, 3 * total + stalls);
            finished = 1;
         end
         kd_due = 0; done_due = 0; gap_chk = 0;
         start = 1'b0; tile_done = 1'b0;
         tile_ready = ideal ? 1'b0 : 1'($urandom_range(0, 1));
         if (in_wait) begin
            check("valid_in_wait", o_valid, 0);
            check("busy_in_wait", o_busy, 1);
            if (n == reset_tile) begin
               reset = 1'b0;
               tick();
               check_zero();
               reset = 1'b1;
               for (int j = 0; j < 3; j++) begin
                  tick();
                  check("post_reset_busy", o_busy, 0);
                  check("post_reset_done", o_done, 0);
                  check("post_reset_k_done", o_kd, 0);
               end
               $display("job on dut%0d reset in WAIT of tile %0d", s, n);
               return;
            end
            if (inject) start = 1'b1;
            if (lat == 0) begin
               tile_done = 1'b1;
               kd_due = exp_q[n].lk;
               done_due = (n == total - 1);
               gap_chk = 1;
               n++;
               in_wait = 0;
            end else begin
               lat--;
            end
         end else if (o_valid != 0) begin
            if (n >= total) begin
               check("extra_command", n, total - 1);
               finished = 1;
            end else begin
               if (!held) begin
                  held = 1;
                  stall_left = 5;
                  if (ideal) check("issue_cycle", cyc, 1 + 3 * n + stalls);
               end
               check_cmd(exp_q[n]);
               if ((n == stall_a || n == stall_b) && stall_left > 0) begin
                  tile_ready = 1'b0;
                  stall_left--;
                  if (inject) tile_done = 1'b1;
               end else if (ideal || $urandom_range(0, 2) != 0) begin
                  tile_ready = 1'b1;
               end else begin
                  tile_ready = 1'b0;
               end
               if (tile_ready) begin
                  $display("dut%0d cmd %0d accepted cycle %0d: r=%0d c=%0d k=%0d", s, n, cyc, o_rb, o_cb, o_kb);
                  in_wait = 1;
                  held = 0;
                  lat = ideal ? 0 : $urandom_range(0, 3);
               end else begin
                  stalls++;
               end
            end
         end
         tick();
      end
      start = 1'b0; tile_ready = 1'b0; tile_done = 1'b0;
      check("job_finished", int'(finished), 1);
      check("done_single_cycle", o_done, 0);
      check("idle_busy", o_busy, 0);
      check("idle_valid", o_valid, 0);
      check("k_done_pulses", kd_seen, kd_exp);
`ifdef TILE_SCHED_PERF_EN
      if (s == 0) begin
         check("cycle_count", int'(a_cc), busy_cyc);
         check("stall_count", int'(a_sc), stalls);
         if (ideal) check("cycle_count_ideal", int'(a_cc), 3 * total - 1 + stalls);
      end
`endif
      $display("job on dut%0d: %0d commands, %0d stall cycles, %0d busy cycles", s, n, stalls, busy_cyc);
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) tick();
      sel = 0;
      check_zero();
      reset = 1'b1;
      tick();
      check_zero();

      // Default sizes: 48 commands, done at cycle 144.
      build(20, 10, 30);
      check("model_cmds", exp_q.size(), 48);
      run_job(0, 1'b1, -1, -1, 1'b0, -1);
      // Backpressure on the 3rd command plus ignored start / tile_done.
      run_job(0, 1'b1, 2, -1, 1'b1, -1);
      // Two stalled tiles: 10 stall cycles.
      run_job(0, 1'b1, 3, 20, 1'b0, -1);
      // Reset in WAIT of the 10th tile, then a clean rerun from (0,0,0).
      run_job(0, 1'b1, -1, -1, 1'b0, 9);
      run_job(0, 1'b1, -1, -1, 1'b0, -1);
      // Randomized engine timing.
      for (int i = 0; i < 3; i++) run_job(0, 1'b0, -1, -1, 1'b0, -1);

      // Edge tiles: 7 x 6 x 8.
      build(7, 6, 8);
      check("model_cmds_edge", exp_q.size(), 8);
      run_job(1, 1'b1, -1, -1, 1'b0, -1);
      run_job(1, 1'b0, -1, -1, 1'b1, -1);

      // Single tile: first_k and last_k both set.
      build(3, 4, 2);
      run_job(2, 1'b1, -1, -1, 1'b0, -1);
      run_job(2, 1'b0, -1, -1, 1'b0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
